// File: rtl/scan_chain_responder.sv
// One element of the multi-project scan chain: synchronises the chain signals into clk,
// shifts/captures a WIDTH-bit register, latches it to the user design, and forwards the chain.
module scan_chain_responder #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             scan_clk_in,
   input  logic             scan_data_in,
   input  logic             scan_select_in,
   input  logic             latch_enable_in,
   output logic             scan_clk_out,
   output logic             scan_data_out,
   output logic             scan_select_out,
   output logic             latch_enable_out,
   output logic [WIDTH-1:0] module_data_in,
   input  logic [WIDTH-1:0] module_data_out,
   output logic [7:0]       shift_count
);

   localparam int LAST = SYNC_STAGES - 1;

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
   logic [SYNC_STAGES-1:0] sel_sync_q, sel_sync_d;
   logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
   logic                   clk_prev_q, clk_prev_d;
   logic                   latch_prev_q, latch_prev_d;
   logic [WIDTH-1:0]       shift_reg_q, shift_reg_d;
   logic [WIDTH-1:0]       data_in_q, data_in_d;
   logic [7:0]             shift_count_q, shift_count_d;

   logic clk_s, data_s, sel_s, latch_s;
   logic clk_rise, latch_rise;

   // All four chain signals share the same depth so data/select stay aligned with the clock sample.
   assign clk_s   = clk_sync_q[LAST];
   assign data_s  = data_sync_q[LAST];
   assign sel_s   = sel_sync_q[LAST];
   assign latch_s = latch_sync_q[LAST];

   assign clk_rise   = clk_s & ~clk_prev_q;
   assign latch_rise = latch_s & ~latch_prev_q;

   always_comb begin
      clk_sync_d    = {clk_sync_q[LAST-1:0], scan_clk_in};
      data_sync_d   = {data_sync_q[LAST-1:0], scan_data_in};
      sel_sync_d    = {sel_sync_q[LAST-1:0], scan_select_in};
      latch_sync_d  = {latch_sync_q[LAST-1:0], latch_enable_in};
      clk_prev_d    = clk_s;
      latch_prev_d  = latch_s;
      shift_reg_d   = shift_reg_q;
      data_in_d     = data_in_q;
      shift_count_d = shift_count_q;

      if (clk_rise) begin
         if (sel_s) begin
            shift_reg_d = module_data_out;
         end else begin
            shift_reg_d = {shift_reg_q[WIDTH-2:0], data_s};
            if (shift_count_q != 8'hFF) begin
               shift_count_d = shift_count_q + 8'd1;
            end
         end
      end

      // A coincident latch sees the pre-shift register and overrides the count.
      if (latch_rise) begin
         data_in_d     = shift_reg_q;
         shift_count_d = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_q    <= '0;
         data_sync_q   <= '0;
         sel_sync_q    <= '0;
         latch_sync_q  <= '0;
         clk_prev_q    <= 1'b0;
         latch_prev_q  <= 1'b0;
         shift_reg_q   <= '0;
         data_in_q     <= '0;
         shift_count_q <= 8'd0;
      end else begin
         clk_sync_q    <= clk_sync_d;
         data_sync_q   <= data_sync_d;
         sel_sync_q    <= sel_sync_d;
         latch_sync_q  <= latch_sync_d;
         clk_prev_q    <= clk_prev_d;
         latch_prev_q  <= latch_prev_d;
         shift_reg_q   <= shift_reg_d;
         data_in_q     <= data_in_d;
         shift_count_q <= shift_count_d;
      end
   end

   assign scan_clk_out     = clk_s;
   assign scan_select_out  = sel_s;
   assign latch_enable_out = latch_s;
   assign scan_data_out    = shift_reg_q[WIDTH-1];
   assign module_data_in   = data_in_q;
   assign shift_count      = shift_count_q;

endmodule

// File: tb/tb_scan_chain_responder.sv
// Bench for scan_chain_responder: a three-element chain checked against a 24-bit chain model
// plus a cycle-history model for the forwarded control signals.
module tb_scan_chain_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic       scan_clk_in, scan_data_in, scan_select_in, latch_enable_in;
   logic [7:0] module_data_out;

   logic       scan_clk_out, scan_data_out, scan_select_out, latch_enable_out;
   logic [7:0] module_data_in, shift_count;
   logic       mid_clk, mid_data, mid_sel, mid_latch;
   logic [7:0] mid_mdi, mid_cnt;
   logic       far_clk, far_data, far_sel, far_latch;
   logic [7:0] far_mdi, far_cnt;

   int vectors = 0;
   int miscompares = 0;

   // Whole chain as one shift register: [7:0] nearest, [15:8] middle, [23:16] farthest.
   logic [23:0] m_chain;
   logic [7:0]  m_mdi;
   logic [7:0]  m_cnt;

   always #5 clk = ~clk;

   scan_chain_responder dut (
      .clk(clk), .reset(reset),
      .scan_clk_in(scan_clk_in), .scan_data_in(scan_data_in),
      .scan_select_in(scan_select_in), .latch_enable_in(latch_enable_in),
      .scan_clk_out(scan_clk_out), .scan_data_out(scan_data_out),
      .scan_select_out(scan_select_out), .latch_enable_out(latch_enable_out),
      .module_data_in(module_data_in), .module_data_out(module_data_out),
      .shift_count(shift_count)
   );

   scan_chain_responder u_mid (
      .clk(clk), .reset(reset),
      .scan_clk_in(scan_clk_out), .scan_data_in(scan_data_out),
      .scan_select_in(scan_select_out), .latch_enable_in(latch_enable_out),
      .scan_clk_out(mid_clk), .scan_data_out(mid_data),
      .scan_select_out(mid_sel), .latch_enable_out(mid_latch),
      .module_data_in(mid_mdi), .module_data_out(8'h00),
      .shift_count(mid_cnt)
   );

   scan_chain_responder u_far (
      .clk(clk), .reset(reset),
      .scan_clk_in(mid_clk), .scan_data_in(mid_data),
      .scan_select_in(mid_sel), .latch_enable_in(mid_latch),
      .scan_clk_out(far_clk), .scan_data_out(far_data),
      .scan_select_out(far_sel), .latch_enable_out(far_latch),
      .module_data_in(far_mdi), .module_data_out(8'h00),
      .shift_count(far_cnt)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic c, input logic d, input logic s, input logic l);
      scan_clk_in     = c;
      scan_data_in    = d;
      scan_select_in  = s;
      latch_enable_in = l;
   endtask

   task automatic model_event(input bit clk_edge, input bit latch_edge, input bit d, input bit sel);
      logic [7:0] old;
      old = m_chain[7:0];
      if (latch_edge) m_mdi = old;
      if (clk_edge) begin
         if (sel) begin
            m_chain = {16'h0000, module_data_out};
         end else begin
            m_chain = {m_chain[22:0], d};
            if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
         end
      end
      if (latch_edge) m_cnt = 8'd0;
   endtask

   task automatic scanPulse(input logic d, input logic sel);
      applyStimulus(1'b1, d, sel, 1'b0);
      tick(4);
      applyStimulus(1'b0, d, sel, 1'b0);
      tick(4);
      model_event(1'b1, 1'b0, d, sel);
   endtask

   task automatic shiftByte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) scanPulse(b[i], 1'b0);
   endtask

   task automatic latchPulse();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick(4);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick(4);
      model_event(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      m_chain = '0;
      m_mdi   = '0;
      m_cnt   = '0;
   endtask

   task automatic checkNear(input string tag);
      checkOutput({tag, ".mdi"}, {24'h0, module_data_in}, {24'h0, m_mdi});
      checkOutput({tag, ".cnt"}, {24'h0, shift_count}, {24'h0, m_cnt});
      checkOutput({tag, ".sdo"}, {31'h0, scan_data_out}, {31'h0, m_chain[7]});
   endtask

   task automatic checkForwardZero(input string tag);
      checkOutput({tag, ".fwd"}, {28'h0, scan_clk_out, scan_select_out, latch_enable_out, scan_data_out}, 32'h0);
   endtask

   initial begin
      logic [7:0]  b;
      logic [2:0]  hist[$];
      logic [31:0] r;

      module_data_out = 8'h00;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      m_chain = '0;
      m_mdi   = '0;
      m_cnt   = '0;

      checkNear("reset");
      checkForwardZero("reset");

      // Reset in the middle of activity, with every forwarded signal high.
      for (int i = 0; i < 3; i++) scanPulse(1'b1, 1'b0);
      module_data_out = 8'hFF;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      tick(4);
      model_event(1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("pre_reset.fwd", {29'h0, scan_clk_out, scan_select_out, latch_enable_out}, 32'h7);
      checkNear("pre_reset");
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1);
      reset = 1'b0;
      m_chain = '0;
      m_mdi   = '0;
      m_cnt   = '0;
      checkNear("mid_reset");
      checkForwardZero("mid_reset");
      tick(4);

      // Shift 0xA5 and check the latch lands exactly three cycles after the input rises.
      shiftByte(8'hA5);
      checkNear("shift_a5");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick(2);
      checkOutput("latch_early", {24'h0, module_data_in}, {24'h0, m_mdi});
      tick(1);
      checkOutput("latch_exact", {24'h0, module_data_in}, 32'hA5);
      checkOutput("latch_cnt", {24'h0, shift_count}, 32'h0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick(4);
      model_event(1'b0, 1'b1, 1'b0, 1'b0);
      checkNear("latch_a5");

      for (int k = 0; k < 4; k++) begin
         b = 8'($urandom);
         shiftByte(b);
         latchPulse();
         checkNear("rand_latch");
      end

      // Capture 0x3C, then a random word, and watch it stream out MSB first.
      for (int k = 0; k < 2; k++) begin
         module_data_out = (k == 0) ? 8'h3C : 8'($urandom);
         scanPulse(1'b0, 1'b1);
         checkNear("capture");
         for (int i = 0; i < 7; i++) begin
            scanPulse(1'b0, 1'b0);
            checkNear("capture_out");
         end
      end

      // Forwarding latency: directed two-cycle check, then a random history comparison.
      doReset();
      tick(3);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      tick(1);
      checkForwardZero("fwd_1cyc");
      tick(1);
      checkOutput("fwd_2cyc", {29'h0, scan_clk_out, scan_select_out, latch_enable_out}, 32'h7);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick(3);
      hist.push_back(3'b000);
      for (int n = 0; n < 40; n++) begin
         r = $urandom;
         applyStimulus(r[0], r[1], r[2], r[3]);
         hist.push_back({r[0], r[2], r[3]});
         tick(1);
         checkOutput("fwd_rand", {29'h0, scan_clk_out, scan_select_out, latch_enable_out},
                     {29'h0, hist[n]});
      end
      doReset();
      tick(3);

      // Three-element chain: first byte in ends up in the farthest element.
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 3; j++) begin
            b = (k == 0) ? 8'(8'h11 * (j + 1)) : 8'($urandom);
            shiftByte(b);
         end
         checkNear("chain_pre");
         latchPulse();
         tick(8);
         checkOutput("chain_near", {24'h0, module_data_in}, {24'h0, m_chain[7:0]});
         checkOutput("chain_mid", {24'h0, mid_mdi}, {24'h0, m_chain[15:8]});
         checkOutput("chain_far", {24'h0, far_mdi}, {24'h0, m_chain[23:16]});
      end
      checkOutput("chain_near_model", {24'h0, m_mdi}, {24'h0, module_data_in});

      // Scan clock and latch rising together: latch sees the pre-shift value.
      shiftByte(8'h0F);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      tick(4);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      tick(4);
      model_event(1'b1, 1'b1, 1'b1, 1'b0);
      checkNear("simul");
      checkOutput("simul_mdi", {24'h0, module_data_in}, 32'h0F);
      checkOutput("simul_sr", {24'h0, dut.shift_reg_q}, {24'h0, m_chain[7:0]});

      // Saturation of the shift counter.
      doReset();
      tick(3);
      for (int i = 0; i < 300; i++) begin
         scanPulse(1'($urandom_range(0, 1)), 1'b0);
         if (i == 253 || i == 254) checkNear("sat_edge");
      end
      checkNear("sat");
      checkOutput("sat_cnt", {24'h0, shift_count}, 32'd255);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
